// File: rtl/spi_master_gen_if.sv
// Control-side bus of spi_master_gen: transfer request, latched transfer
// attributes and completion status.
//   start   : transfer request (honoured only when the master is idle)
//   mode    : {CPOL,CPHA} for the requested transfer
//   cs_sel  : index of the chip select to assert
//   tx_data : word to transmit
//   rx_data : last received word
//   busy    : transfer in progress
//   done    : one-cycle completion pulse
interface spi_master_gen_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CS_W       = 1
) ();
    logic                  start;
    logic [1:0]            mode;
    logic [CS_W-1:0]       cs_sel;
    logic [DATA_WIDTH-1:0] tx_data;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  busy;
    logic                  done;

    // Control logic issuing transfers.
    modport master (
        output start, mode, cs_sel, tx_data,
        input  rx_data, busy, done
    );

    // SPI master serving the requests.
    modport slave (
        input  start, mode, cs_sel, tx_data,
        output rx_data, busy, done
    );
endinterface

// File: rtl/spi_master_gen.sv
// Parametrised full-duplex SPI master: one transfer of DATA_WIDTH bits per
// accepted start, SPI mode chosen per transfer, NUM_CS active-low selects.
// Ports:
//   sys_clk, rstn : system clock (rising edge), async active-low reset
//   ctl           : control bus (start/mode/cs_sel/tx_data in,
//                   rx_data/busy/done out), slave side
//   sclk, mosi    : SPI clock and serial data out
//   miso          : serial data in
//   cs_n          : active-low chip selects
module spi_master_gen #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned NUM_CS     = 1,
    parameter int unsigned LSB_FIRST  = 0
) (
    input  logic               sys_clk,
    input  logic               rstn,
    spi_master_gen_if.slave    ctl,
    output logic               sclk,
    output logic               mosi,
    input  logic               miso,
    output logic [NUM_CS-1:0]  cs_n
);
    localparam int unsigned CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int unsigned DIV_W  = $clog2(CLK_DIV + 1);
    localparam int unsigned EDGE_W = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_UNLOAD
    } state_t;

    state_t                state;
    logic [DIV_W-1:0]      half_cnt;
    logic [EDGE_W-1:0]     edge_cnt;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic                  cpol;
    logic                  cpha;

    // Half-period timing and edge classification.
    logic fire_c;
    logic last_edge_c;
    logic sample_c;
    assign fire_c      = (half_cnt == DIV_LAST);
    assign last_edge_c = (edge_cnt == EDGE_LAST);
    // Edge index is edge_cnt+1, so an even edge_cnt means a leading edge.
    // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
    assign sample_c    = (~edge_cnt[0]) ^ cpha;

    // Bit-order dependent shift paths for tx, rx and the load-time first bit.
    logic                  tx_bit_c;
    logic [DATA_WIDTH-1:0] tx_shift_c;
    logic                  load_bit_c;
    logic [DATA_WIDTH-1:0] load_shift_c;
    logic [DATA_WIDTH-1:0] rx_next_c;
    always_comb begin
        if (LSB_FIRST != 0) begin
            tx_bit_c     = tx_sr[0];
            tx_shift_c   = tx_sr >> 1;
            load_bit_c   = ctl.tx_data[0];
            load_shift_c = ctl.tx_data >> 1;
            rx_next_c    = {miso, rx_sr[DATA_WIDTH-1:1]};
        end else begin
            tx_bit_c     = tx_sr[DATA_WIDTH-1];
            tx_shift_c   = tx_sr << 1;
            load_bit_c   = ctl.tx_data[DATA_WIDTH-1];
            load_shift_c = ctl.tx_data << 1;
            rx_next_c    = {rx_sr[DATA_WIDTH-2:0], miso};
        end
    end

    // Transfer sequencer; every output is a register updated here.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            half_cnt    <= '0;
            edge_cnt    <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            cpol        <= 1'b0;
            cpha        <= 1'b0;
            sclk        <= 1'b0;
            mosi        <= 1'b0;
            cs_n        <= '1;
            ctl.busy    <= 1'b0;
            ctl.done    <= 1'b0;
            ctl.rx_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ctl.done <= 1'b0;
                    if (ctl.start) begin
                        // Accept: latch everything the transfer depends on.
                        state    <= ST_LOAD;
                        ctl.busy <= 1'b1;
                        cpol     <= ctl.mode[1];
                        cpha     <= ctl.mode[0];
                        sclk     <= ctl.mode[1];
                        half_cnt <= '0;
                        edge_cnt <= '0;
                        rx_sr    <= '0;
                        for (int unsigned i = 0; i < NUM_CS; i++) begin
                            cs_n[i] <= (ctl.cs_sel != CS_W'(i));
                        end
                        // CPHA=0 needs the first bit on the wire before edge 1.
                        if (!ctl.mode[0]) begin
                            mosi  <= load_bit_c;
                            tx_sr <= load_shift_c;
                        end else begin
                            tx_sr <= ctl.tx_data;
                        end
                    end else begin
                        ctl.busy <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    state <= ST_SETUP;
                end

                // SETUP ends with edge 1; SHIFT produces the remaining edges.
                ST_SETUP, ST_SHIFT: begin
                    if (fire_c) begin
                        half_cnt <= '0;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + EDGE_W'(1);
                        if (sample_c) begin
                            rx_sr <= rx_next_c;
                        end else if (cpha || !last_edge_c) begin
                            mosi  <= tx_bit_c;
                            tx_sr <= tx_shift_c;
                        end
                        state <= last_edge_c ? ST_HOLD : ST_SHIFT;
                    end else begin
                        half_cnt <= half_cnt + DIV_W'(1);
                    end
                end

                ST_HOLD: begin
                    if (fire_c) begin
                        half_cnt <= '0;
                        state    <= ST_UNLOAD;
                    end else begin
                        half_cnt <= half_cnt + DIV_W'(1);
                    end
                end

                // Publish the word; busy stays up through the done cycle so a
                // held start can chain straight into the next LOAD.
                ST_UNLOAD: begin
                    state       <= ST_IDLE;
                    ctl.rx_data <= rx_sr;
                    ctl.done    <= 1'b1;
                    cs_n        <= '1;
                    mosi        <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_gen.sv
// Scoreboard bench for spi_master_gen: dut_a (W=8, DIV=2, 5 selects, MSB
// first, loopback) and dut_b (W=12, DIV=1, LSB first, slave model).
module tb_spi_master_gen;
    typedef struct {
        logic [11:0] rx;
        int          done_cyc;
        logic [4:0]  cs;
        logic [1:0]  mode;
        logic [11:0] mo;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic       rstn_a, rstn_b;
    logic       sclk_a, mosi_a, miso_a;
    logic [4:0] cs_n_a;
    logic       sclk_b, mosi_b;
    logic       miso_b = 1'b0;
    logic [0:0] cs_n_b;

    spi_master_gen_if #(.DATA_WIDTH(8),  .CS_W(3)) if_a ();
    spi_master_gen_if #(.DATA_WIDTH(12), .CS_W(1)) if_b ();

    assign miso_a = mosi_a;

    spi_master_gen #(.DATA_WIDTH(8), .CLK_DIV(2), .NUM_CS(5), .LSB_FIRST(0)) dut_a (
        .sys_clk (clk),
        .rstn    (rstn_a),
        .ctl     (if_a.slave),
        .sclk    (sclk_a),
        .mosi    (mosi_a),
        .miso    (miso_a),
        .cs_n    (cs_n_a)
    );

    spi_master_gen #(.DATA_WIDTH(12), .CLK_DIV(1), .NUM_CS(1), .LSB_FIRST(1)) dut_b (
        .sys_clk (clk),
        .rstn    (rstn_b),
        .ctl     (if_b.slave),
        .sclk    (sclk_b),
        .mosi    (mosi_b),
        .miso    (miso_b),
        .cs_n    (cs_n_b)
    );

    exp_t qa[$];
    exp_t qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // ---------------- dut_a monitor ----------------
    int         rises_a = 0, viol_a = 0, csvar_a = 0;
    logic [4:0] cs_cap_a = 5'h1f;
    logic       psclk_a = 1'b0, pmosi_a = 1'b0, pbusy_a = 1'b0;

    always @(negedge clk) begin
        if (!rstn_a) begin
            rises_a = 0; viol_a = 0; csvar_a = 0;
        end else begin
            if (if_a.busy && !pbusy_a) begin
                rises_a = 0; viol_a = 0; csvar_a = 0;
                cs_cap_a = cs_n_a;
            end else if (pbusy_a && if_a.busy && !if_a.done) begin
                if (sclk_a && !psclk_a) rises_a++;
                if (mosi_a != pmosi_a && qa.size() != 0) begin
                    if (!(sclk_a != psclk_a && sclk_a == (qa[0].mode[1] ^ qa[0].mode[0])))
                        viol_a++;
                end
                if (cs_n_a != cs_cap_a) csvar_a++;
            end
            if (if_a.done) begin
                chk("a_done_expected", 32'(qa.size() != 0), 32'(1));
                if (qa.size() != 0) begin
                    exp_t e;
                    e = qa.pop_front();
                    chk("a_rx_data",    32'(if_a.rx_data), 32'(e.rx));
                    chk("a_done_cycle", 32'(cyc),          32'(e.done_cyc));
                    chk("a_sclk_rises", 32'(rises_a),      32'(8));
                    chk("a_mosi_edge",  32'(viol_a),       32'(0));
                    chk("a_sclk_idle",  32'(sclk_a),       32'(e.mode[1]));
                    chk("a_cs_n",       32'(cs_cap_a),     32'(e.cs));
                    chk("a_cs_stable",  32'(csvar_a),      32'(0));
                end
            end
        end
        psclk_a = sclk_a;
        pmosi_a = mosi_a;
        pbusy_a = if_a.busy;
    end

    // ---------------- dut_b slave model and monitor ----------------
    logic [11:0] pat_b = 12'h05A;
    int          sl_idx = 0;
    logic        scs_b = 1'b1, ssclk_b = 1'b0;

    // Mode-0 slave: first bit on select, next bit on each falling sclk.
    always @(negedge clk) begin
        if (!cs_n_b[0] && scs_b) begin
            miso_b = pat_b[0];
            sl_idx = 1;
        end else if (!cs_n_b[0] && ssclk_b && !sclk_b) begin
            if (sl_idx < 12) miso_b = pat_b[sl_idx];
            sl_idx++;
        end
        scs_b   = cs_n_b[0];
        ssclk_b = sclk_b;
    end

    logic [11:0] cap_b = '0;
    logic        psclk_b = 1'b0;
    int          hi_run = 0, last_gap = 0;

    always @(negedge clk) begin
        if (!rstn_b) begin
            cap_b = '0;
            hi_run = 0;
        end else begin
            if (!cs_n_b[0] && !psclk_b && sclk_b) cap_b = {mosi_b, cap_b[11:1]};
            if (cs_n_b[0]) hi_run++;
            else if (hi_run != 0) begin
                last_gap = hi_run;
                hi_run = 0;
            end
            if (if_b.done) begin
                chk("b_done_expected", 32'(qb.size() != 0), 32'(1));
                if (qb.size() != 0) begin
                    exp_t e;
                    e = qb.pop_front();
                    chk("b_rx_data",    32'(if_b.rx_data), 32'(e.rx));
                    chk("b_done_cycle", 32'(cyc),          32'(e.done_cyc));
                    chk("b_mosi_order", 32'(cap_b),        32'(e.mo));
                end
                cap_b = '0;
            end
        end
        psclk_b = sclk_b;
    end

    // ---------------- stimulus ----------------
    task automatic go_a(input logic [1:0] m, input logic [2:0] c, input logic [7:0] tx, input bit push);
        exp_t e;
        @(negedge clk);
        if_a.mode    = m;
        if_a.cs_sel  = c;
        if_a.tx_data = tx;
        if_a.start   = 1'b1;
        if (push) begin
            e.rx       = 12'(tx);
            e.done_cyc = cyc + 1 + 36;
            e.cs       = 5'h1f;
            if (c < 3'd5) e.cs[c] = 1'b0;
            e.mode     = m;
            e.mo       = '0;
            qa.push_back(e);
        end
        @(negedge clk);
        if_a.start = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while ((qa.size() != 0 || if_a.busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("a_wait_bounded", 32'(n < 400), 32'(1));
    endtask

    task automatic wait_idle_b();
        int n = 0;
        while ((qb.size() != 0 || if_b.busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("b_wait_bounded", 32'(n < 400), 32'(1));
    endtask

    initial begin
        exp_t e;
        int   s;
        rstn_a = 1'b0; rstn_b = 1'b0;
        if_a.start = 1'b0; if_a.mode = 2'b00; if_a.cs_sel = '0; if_a.tx_data = '0;
        if_b.start = 1'b0; if_b.mode = 2'b00; if_b.cs_sel = '0; if_b.tx_data = '0;
        repeat (3) @(negedge clk);

        chk("rst_cs_n",  32'(cs_n_a),       32'(5'h1f));
        chk("rst_sclk",  32'(sclk_a),       32'(0));
        chk("rst_mosi",  32'(mosi_a),       32'(0));
        chk("rst_busy",  32'(if_a.busy),    32'(0));
        chk("rst_done",  32'(if_a.done),    32'(0));
        chk("rst_rx",    32'(if_a.rx_data), 32'(0));
        chk("rst_b_cs",  32'(cs_n_b),       32'(1));
        chk("rst_b_rx",  32'(if_b.rx_data), 32'(0));

        @(negedge clk);
        rstn_a = 1'b1; rstn_b = 1'b1;
        repeat (2) @(negedge clk);

        // Loopback, mode 0.
        go_a(2'b00, 3'd0, 8'hA5, 1'b1);
        wait_idle_a();

        // Loopback, modes 1-3; mode 1 also sees a start and input churn mid-transfer.
        for (int m = 1; m < 4; m++) begin
            go_a(2'(m), 3'd0, 8'h3C, 1'b1);
            if (m == 1) begin
                repeat (10) @(negedge clk);
                if_a.start = 1'b1; if_a.tx_data = 8'hFF; if_a.mode = 2'b11; if_a.cs_sel = 3'd3;
                @(negedge clk);
                if_a.start = 1'b0;
            end
            wait_idle_a();
            repeat (40) @(negedge clk);
        end

        // Chip-select routing, including an out-of-range select.
        go_a(2'b11, 3'd2, 8'h96, 1'b1);
        wait_idle_a();
        go_a(2'b11, 3'd5, 8'h69, 1'b1);
        wait_idle_a();
        chk("a_rx_before_abort", 32'(if_a.rx_data), 32'(8'h69));

        // Abort with reset after the fifth sclk edge.
        go_a(2'b11, 3'd0, 8'h81, 1'b0);
        begin
            int   tg = 0, n = 0;
            logic ps;
            ps = sclk_a;
            while (tg < 5 && n < 200) begin
                @(negedge clk);
                n++;
                if (sclk_a != ps) tg++;
                ps = sclk_a;
            end
            chk("abort_reached_edge5", 32'(tg), 32'(5));
        end
        rstn_a = 1'b0;
        #1;
        chk("abort_cs_n", 32'(cs_n_a),       32'(5'h1f));
        chk("abort_sclk", 32'(sclk_a),       32'(0));
        chk("abort_rx",   32'(if_a.rx_data), 32'(0));
        chk("abort_busy", 32'(if_a.busy),    32'(0));
        chk("abort_done", 32'(if_a.done),    32'(0));
        repeat (3) @(negedge clk);
        rstn_a = 1'b1;
        repeat (2) @(negedge clk);
        go_a(2'b00, 3'd0, 8'hA5, 1'b1);
        wait_idle_a();

        // dut_b: slave returns 0x05A, LSB first.
        @(negedge clk);
        if_b.tx_data = 12'h0FF;
        if_b.start   = 1'b1;
        e.rx = 12'h05A; e.done_cyc = cyc + 1 + 27; e.cs = '0; e.mode = 2'b00; e.mo = 12'h0FF;
        qb.push_back(e);
        @(negedge clk);
        if_b.start = 1'b0;
        wait_idle_b();
        repeat (5) @(negedge clk);

        // dut_b: back-to-back with start held across done; tx changes mid-transfer.
        @(negedge clk);
        s = cyc + 1;
        if_b.tx_data = 12'h0FF;
        if_b.start   = 1'b1;
        e.rx = 12'h05A; e.done_cyc = s + 27; e.mo = 12'h0FF;
        qb.push_back(e);
        e.rx = 12'h05A; e.done_cyc = s + 28 + 27; e.mo = 12'h123;
        qb.push_back(e);
        repeat (5) @(negedge clk);
        if_b.tx_data = 12'h123;
        begin
            int n = 0;
            while (cyc < s + 28 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        if_b.start = 1'b0;
        wait_idle_b();
        chk("b_cs_gap", 32'(last_gap), 32'(1));

        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
